// File: rtl/exc_pkg.sv
// Shared types and constants for the writeback exception/ERTN commit controller.
package exc_pkg;

    localparam int unsigned ECODE_W = 6;
    localparam int unsigned ESUB_W  = 9;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DRAIN_W = 4;

    localparam logic [ECODE_W-1:0] ECODE_INT = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_ADE = 6'h08;
    localparam logic [ECODE_W-1:0] ECODE_ALE = 6'h09;
    localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_INE = 6'h0D;

    localparam logic [ESUB_W-1:0] ESUBCODE_NONE = 9'h000;
    localparam logic [ESUB_W-1:0] ESUBCODE_ADEF = 9'h000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_FLUSH,
        S_REDIRECT
    } state_e;

    typedef enum logic {
        KIND_EXC,
        KIND_ERTN
    } kind_e;

    typedef struct packed {
        logic                take;
        kind_e               kind;
        logic [ECODE_W-1:0]  ecode;
        logic [ESUB_W-1:0]   esubcode;
    } prio_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: picks the single winning event among interrupt, exception flags and ERTN.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic  has_int_i,
    input  logic  adef_i,
    input  logic  ine_i,
    input  logic  sys_i,
    input  logic  brk_i,
    input  logic  ale_i,
    input  logic  ertn_i,
    output prio_t res_c
);

    // Interrupt beats every exception; ERTN only wins when nothing else is present.
    always_comb begin
        res_c          = '0;
        res_c.kind     = KIND_EXC;
        res_c.esubcode = ESUBCODE_NONE;
        res_c.take     = has_int_i | adef_i | ine_i | sys_i | brk_i | ale_i | ertn_i;
        if (has_int_i) begin
            res_c.ecode = ECODE_INT;
        end else if (adef_i) begin
            res_c.ecode    = ECODE_ADE;
            res_c.esubcode = ESUBCODE_ADEF;
        end else if (ine_i) begin
            res_c.ecode = ECODE_INE;
        end else if (sys_i) begin
            res_c.ecode = ECODE_SYS;
        end else if (brk_i) begin
            res_c.ecode = ECODE_BRK;
        end else if (ale_i) begin
            res_c.ecode = ECODE_ALE;
        end else if (ertn_i) begin
            res_c.kind = KIND_ERTN;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Writeback-stage exception/ERTN commit controller: commit pulse to CSR file,
// timed pipeline drain, then redirect handshake with fetch.
module exc_commit_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic [ADDR_W-1:0]   wb_pc,
    input  logic [ADDR_W-1:0]   wb_vaddr,
    input  logic                wb_exc_adef,
    input  logic                wb_exc_ine,
    input  logic                wb_exc_sys,
    input  logic                wb_exc_brk,
    input  logic                wb_exc_ale,
    input  logic                wb_ertn,
    input  logic                has_int,
    input  logic [ADDR_W-1:0]   ex_entry,
    input  logic [ADDR_W-1:0]   ertn_entry,
    output logic                wb_ex,
    output logic                ertn_flush,
    output logic [ECODE_W-1:0]  wb_ecode,
    output logic [ESUB_W-1:0]   wb_esubcode,
    output logic [ADDR_W-1:0]   wb_ex_pc,
    output logic [ADDR_W-1:0]   wb_ex_vaddr,
    output logic                flush_pipe,
    output logic                redirect_valid,
    input  logic                redirect_ready,
    output logic [ADDR_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]    exc_count
);

    prio_t               prio_c;
    state_e              state_q, state_d;
    logic [DRAIN_W-1:0]  cnt_q, cnt_d;
    kind_e               kind_q, kind_d;
    logic                accept_c;

    logic                wb_ready_q;
    logic                wb_ex_q;
    logic                ertn_flush_q;
    logic                flush_pipe_q;
    logic                redirect_valid_q;
    logic [ECODE_W-1:0]  ecode_q;
    logic [ESUB_W-1:0]   esub_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   vaddr_q;
    logic [ADDR_W-1:0]   redirect_pc_q;
    logic [CNT_W-1:0]    exc_count_q;

    exc_prio_enc u_prio (
        .has_int_i (has_int),
        .adef_i    (wb_exc_adef),
        .ine_i     (wb_exc_ine),
        .sys_i     (wb_exc_sys),
        .brk_i     (wb_exc_brk),
        .ale_i     (wb_exc_ale),
        .ertn_i    (wb_ertn),
        .res_c     (prio_c)
    );

    // Next-state logic; WB inputs only matter in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wb_valid && prio_c.take) begin
                    accept_c = 1'b1;
                    kind_d   = prio_c.kind;
                    state_d  = S_COMMIT;
                end
            end
            S_COMMIT: begin
                cnt_d   = DRAIN_W'(FLUSH_CYCLES - 1);
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - DRAIN_W'(1);
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            kind_q           <= KIND_EXC;
            wb_ready_q       <= 1'b1;
            wb_ex_q          <= 1'b0;
            ertn_flush_q     <= 1'b0;
            flush_pipe_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            ecode_q          <= '0;
            esub_q           <= '0;
            pc_q             <= '0;
            vaddr_q          <= '0;
            redirect_pc_q    <= '0;
            exc_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            kind_q           <= kind_d;
            wb_ready_q       <= (state_d == S_IDLE);
            wb_ex_q          <= (state_d == S_COMMIT) && (kind_d == KIND_EXC);
            ertn_flush_q     <= (state_d == S_COMMIT) && (kind_d == KIND_ERTN);
            flush_pipe_q     <= (state_d != S_IDLE);
            redirect_valid_q <= (state_d == S_REDIRECT);
            if (accept_c) begin
                ecode_q <= prio_c.ecode;
                esub_q  <= prio_c.esubcode;
                pc_q    <= wb_pc;
                vaddr_q <= wb_vaddr;
            end
            // Redirect target is sampled from the CSR file during the commit cycle.
            if (state_q == S_COMMIT) begin
                redirect_pc_q <= (kind_q == KIND_EXC) ? ex_entry : ertn_entry;
                if ((kind_q == KIND_EXC) && (exc_count_q != '1)) begin
                    exc_count_q <= exc_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign wb_ready       = wb_ready_q;
    assign wb_ex          = wb_ex_q;
    assign ertn_flush     = ertn_flush_q;
    assign flush_pipe     = flush_pipe_q;
    assign redirect_valid = redirect_valid_q;
    assign wb_ecode       = ecode_q;
    assign wb_esubcode    = esub_q;
    assign wb_ex_pc       = pc_q;
    assign wb_ex_vaddr    = vaddr_q;
    assign redirect_pc    = redirect_pc_q;
    assign exc_count      = exc_count_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: timestamp-based reference model, randomized and directed stimulus.
module tb_exc_commit_ctrl;

    localparam int unsigned FC    = 2;
    localparam int unsigned CNT_W = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_pc, wb_vaddr;
    logic        wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale, wb_ertn, has_int;
    logic [31:0] ex_entry, ertn_entry;
    logic        wb_ex, ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_ex_pc, wb_ex_vaddr;
    logic        flush_pipe, redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic [CNT_W-1:0] exc_count;

    exc_commit_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .wb_exc_adef(wb_exc_adef), .wb_exc_ine(wb_exc_ine), .wb_exc_sys(wb_exc_sys),
        .wb_exc_brk(wb_exc_brk), .wb_exc_ale(wb_exc_ale), .wb_ertn(wb_ertn),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_ex_pc(wb_ex_pc), .wb_ex_vaddr(wb_ex_vaddr), .flush_pipe(flush_pipe),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic ertn; logic [5:0] ecode; logic [31:0] pc; logic [31:0] vaddr; } commit_t;
    typedef struct { logic [31:0] pc; int count; } redir_t;

    commit_t cq[$];
    redir_t  rq[$];
    int checks = 0;
    int errors = 0;

    // staged stimulus for the next cycle (bit0 adef, 1 ine, 2 sys, 3 brk, 4 ale)
    logic        s_valid, s_ertn, s_int, s_rready;
    logic [4:0]  s_flags;
    logic [31:0] s_pc, s_vaddr, s_exe, s_erte;

    // reference model: idle flag plus timestamp of the accepting cycle
    bit  m_idle = 1'b1;
    bit  m_ertn = 1'b0;
    int  m_count = 0;
    int  cyc = 0;
    int  acc = 0;
    bit  chk_en = 1'b0;
    bit  exp_ready, exp_flush, exp_rv, exp_commit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_ecode(input logic irq, input logic [4:0] f);
        logic [5:0] codes [5];
        codes = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        if (irq) return 6'h00;
        for (int i = 0; i < 5; i++) if (f[i]) return codes[i];
        return 6'h00;
    endfunction

    task automatic cycle();
        commit_t c;
        redir_t  r;
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        exp_ready  = m_idle;
        exp_flush  = !m_idle;
        exp_rv     = !m_idle && (cyc >= acc + 2 + int'(FC));
        exp_commit = !m_idle && (cyc == acc + 1);
        wb_valid = s_valid; wb_pc = s_pc; wb_vaddr = s_vaddr;
        {wb_exc_ale, wb_exc_brk, wb_exc_sys, wb_exc_ine, wb_exc_adef} = s_flags;
        wb_ertn = s_ertn; has_int = s_int; ex_entry = s_exe; ertn_entry = s_erte;
        redirect_ready = s_rready;
        if (exp_commit) begin
            r.pc = m_ertn ? s_erte : s_exe;
            r.count = m_count;
            rq.push_back(r);
        end
        if (m_idle && s_valid && (s_flags != 5'd0 || s_ertn || s_int)) begin
            c.ertn  = !(s_int || s_flags != 5'd0);
            c.ecode = exp_ecode(s_int, s_flags);
            c.pc    = s_pc;
            c.vaddr = s_vaddr;
            cq.push_back(c);
            m_ertn = c.ertn;
            if (!c.ertn) m_count++;
            m_idle = 1'b0;
            acc    = cyc;
        end else if (exp_rv && s_rready) begin
            m_idle = 1'b1;
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1; chk_en = 1'b0;
        wb_valid = 1'b0; redirect_ready = 1'b0;
        repeat (n - 1) @(posedge clk);
        cq.delete(); rq.delete();
        m_idle = 1'b1; m_count = 0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_wb();
        s_valid = 1'b0; s_flags = 5'd0; s_ertn = 1'b0; s_int = 1'b0;
    endtask

    task automatic run_until_idle();
        int n = 0;
        while (!m_idle && n < 60) begin cycle(); n++; end
        cycle();
        chk("returned_to_idle", 32'(m_idle), 32'd1);
    endtask

    // monitor: per-cycle control checks and scoreboard pops on DUT output events
    always @(negedge clk) begin
        commit_t c;
        redir_t  r;
        if (!reset && chk_en) begin
            chk("wb_ready", 32'(wb_ready), 32'(exp_ready));
            chk("flush_pipe", 32'(flush_pipe), 32'(exp_flush));
            chk("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
            chk("commit_timing", 32'(wb_ex | ertn_flush), 32'(exp_commit));
            if (wb_ex && ertn_flush) chk("ex_and_ertn_exclusive", 32'd1, 32'd0);
            if (wb_ex || ertn_flush) begin
                if (cq.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
                else begin
                    c = cq.pop_front();
                    chk("commit_is_ertn", 32'(ertn_flush), 32'(c.ertn));
                    if (!c.ertn) begin
                        chk("ecode", 32'(wb_ecode), 32'(c.ecode));
                        chk("esubcode", 32'(wb_esubcode), 32'd0);
                        chk("ex_pc", wb_ex_pc, c.pc);
                        chk("ex_vaddr", wb_ex_vaddr, c.vaddr);
                    end
                end
            end
            if (redirect_valid && rq.size() != 0) chk("redirect_pc_stable", redirect_pc, rq[0].pc);
            if (redirect_valid && redirect_ready) begin
                if (rq.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
                else begin
                    r = rq.pop_front();
                    chk("redirect_pc", redirect_pc, r.pc);
                    chk("exc_count_at_redirect", 32'(exc_count), 32'(r.count));
                end
            end
        end
    end

    initial begin
        clear_wb();
        s_pc = '0; s_vaddr = '0; s_exe = '0; s_erte = '0; s_rready = 1'b1;
        reset = 1'b1; wb_valid = 1'b0; redirect_ready = 1'b0;
        wb_pc = '0; wb_vaddr = '0; ex_entry = '0; ertn_entry = '0;
        {wb_exc_ale, wb_exc_brk, wb_exc_sys, wb_exc_ine, wb_exc_adef} = 5'd0;
        wb_ertn = 1'b0; has_int = 1'b0;
        do_reset(3);
        cycle();
        chk("reset_wb_ex", 32'(wb_ex), 32'd0);
        chk("reset_exc_count", 32'(exc_count), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);

        // SYS exception
        s_valid = 1'b1; s_flags = 5'b00100; s_pc = 32'h1C000010; s_vaddr = 32'h1234;
        s_exe = 32'h1C008000; s_rready = 1'b1;
        cycle(); clear_wb();
        run_until_idle();
        chk("sys_ecode", 32'(wb_ecode), 32'h0B);
        chk("sys_pc", wb_ex_pc, 32'h1C000010);
        chk("sys_count", 32'(exc_count), 32'd1);

        // INE + ALE + interrupt: interrupt wins, single commit
        s_valid = 1'b1; s_flags = 5'b10010; s_int = 1'b1; s_pc = 32'h1C000020;
        cycle(); clear_wb();
        run_until_idle();
        chk("int_ecode", 32'(wb_ecode), 32'h00);
        chk("int_count", 32'(exc_count), 32'd2);

        // ERTN
        s_valid = 1'b1; s_ertn = 1'b1; s_pc = 32'h1C000030; s_erte = 32'h1C000200;
        cycle(); clear_wb();
        run_until_idle();
        chk("ertn_count", 32'(exc_count), 32'd2);
        chk("ertn_redirect_pc", redirect_pc, 32'h1C000200);

        // interrupt pending without a valid instruction
        s_int = 1'b1; s_valid = 1'b0;
        run(5);
        s_valid = 1'b1; s_pc = 32'h1C000040;
        cycle(); clear_wb();
        run_until_idle();
        chk("int_attach_pc", wb_ex_pc, 32'h1C000040);
        chk("int_attach_ecode", 32'(wb_ecode), 32'h00);

        // redirect back-pressure
        s_rready = 1'b0; s_valid = 1'b1; s_flags = 5'b01000; s_pc = 32'h1C000050;
        cycle(); clear_wb();
        run(2 + FC + 6);
        s_rready = 1'b1;
        run_until_idle();
        chk("brk_ecode", 32'(wb_ecode), 32'h0C);

        // reset during FLUSH
        s_valid = 1'b1; s_flags = 5'b00001; s_pc = 32'h1C000060;
        cycle(); clear_wb();
        run(2);
        do_reset(1);
        run(4);
        chk("post_reset_count", 32'(exc_count), 32'd0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            s_valid  = 1'($urandom_range(0, 1));
            s_flags  = {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                        1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                        1'($urandom_range(0, 7) == 0)};
            s_ertn   = 1'($urandom_range(0, 5) == 0);
            s_int    = 1'($urandom_range(0, 9) == 0);
            s_pc     = $urandom; s_vaddr = $urandom;
            s_exe    = $urandom; s_erte  = $urandom;
            s_rready = 1'($urandom_range(0, 1));
            if (i % 700 == 699) do_reset(1 + int'($urandom_range(0, 2)));
            else cycle();
        end

        clear_wb(); s_rready = 1'b1;
        run(3 + FC + 10);
        chk("commit_queue_drained", 32'(cq.size()), 32'd0);
        chk("redirect_queue_drained", 32'(rq.size()), 32'd0);
        chk("final_count", 32'(exc_count), 32'(m_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
